lpif_txrx_slave_gbox: RTL and testbench
=======================================

LPIF_TXRX_SLAVE_GBOX -- requirements
Module: lpif_txrx_slave_gbox

Interface
REQ-001 SHALL have parameter DATA_W, default 128, LPIF flit data width in bits.
REQ-002 SHALL have parameter CRC_W, default 16, CRC field width.
REQ-003 SHALL derive FW = 4+2+DATA_W+1+CRC_W+1+1 (153 at default) and HW = ceil(FW/2) (77 at default).
REQ-004 Port: lclk  input  1  single block clock; all logic rising-edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: m_gen2_mode  input  1  1 = full-rate, one link word per flit; 0 = half-rate, two link words per flit.
REQ-007 Ports: ustrm_state/protid/data/dvalid/crc/crc_valid/valid  input  4/2/DATA_W/1/CRC_W/1/1  upstream flit fields.
REQ-008 Port: ustrm_ready  output  1  tx buffer can accept a flit.
REQ-009 Ports: txfifo_upstream_data  output  FW; txfifo_upstream_phase  output  1; txfifo_upstream_push  output  1; txfifo_upstream_ready  input  1 (link FIFO not full).
REQ-010 Ports: rxfifo_downstream_data  input  FW; rxfifo_downstream_phase  input  1; rxfifo_downstream_valid  input  1.
REQ-011 Ports: dstrm_state/protid/data/dvalid/crc/crc_valid/valid  output  same widths as ustrm_*  registered downstream flit.
REQ-012 Ports: rx_align_err  output  1  sticky phase error; rx_err_cnt  output  8  error count.

Function
REQ-013 Flit packing SHALL be LSB-first: state[3:0], protid, data, dvalid, crc, crc_valid, valid (valid in bit FW-1).
REQ-014 A flit SHALL be accepted in a cycle where ustrm_valid=1 and ustrm_ready=1; ustrm_valid=0 cycles SHALL NOT be accepted.
REQ-015 Tx SHALL hold a 2-entry flit FIFO; ustrm_ready = not full; simultaneous accept and drain at full SHALL NOT be allowed (ready low when full).
REQ-016 Tx FSM states: IDLE, SEND_LO, SEND_HI; mode SHALL be sampled when a flit leaves IDLE and held until that flit completes.
REQ-017 Gen2: push SHALL assert with full packed flit, phase=0, earliest one cycle after acceptance.
REQ-018 Gen1: SEND_LO pushes packed[HW-1:0] zero-extended with phase=0, then SEND_HI pushes packed[FW-1:HW] zero-extended with phase=1, on consecutive ready cycles.
REQ-019 txfifo_upstream_push SHALL assert only when txfifo_upstream_ready=1; ready low SHALL hold data, phase and FSM state unchanged.
REQ-020 Back-to-back flits SHALL stream without idle cycles while ready stays high (gen2: 1 flit/cycle; gen1: 1 flit/2 cycles).
REQ-021 Rx FSM states: RX_LO, RX_HI; only rxfifo_downstream_valid=1 cycles SHALL be processed.
REQ-022 Rx gen2: valid word SHALL drive dstrm_* outputs on the next cycle, for exactly one cycle.
REQ-023 Rx gen1: phase-0 word stored, move to RX_HI; phase-1 word in RX_HI SHALL emit reassembled flit next cycle, return to RX_LO.
REQ-024 Rx gen1 phase-1 word in RX_LO SHALL be dropped, set rx_align_err, count one error.
REQ-025 Rx gen1 phase-0 word in RX_HI SHALL discard stored half, store new half, stay RX_HI, count one error.
REQ-026 Rx gen2 phase-1 word SHALL be dropped and counted as error.
REQ-027 When no flit emitted, all dstrm_* outputs SHALL be 0 (dstrm_valid=0).

Reset
REQ-028 reset SHALL asynchronously force: tx FIFO empty, FSMs to IDLE/RX_LO, ustrm_ready=0 during reset and 1 the cycle after release, push=0, phase=0, txfifo data=0, dstrm_*=0, rx_align_err=0, rx_err_cnt=0.
REQ-029 Reset mid-flit SHALL discard partial tx and rx flits; no half flit SHALL be emitted after release.

Configuration
REQ-030 Macro LPIF_TXRX_SLAVE_GBOX_ERR_CNT_EN defined: rx_err_cnt SHALL increment per REQ-024..026 error, saturating at 255.
REQ-031 Macro undefined: rx_err_cnt SHALL be constant 0; rx_align_err and all other behaviour unchanged.

Verification
REQ-032 Gen2, ready=1, flit data=128'hA5..A5 valid=1 accepted cycle 0 -> push cycle 1, data[133:6]=A5..A5, phase=0, dstrm loopback emits identical flit cycle 2.
REQ-033 Gen1, 3 back-to-back flits -> 6 pushes phases 0,1,0,1,0,1 on consecutive cycles; loopback reassembles all 3 bit-exact.
REQ-034 Gen1, txfifo_upstream_ready=0 for 5 cycles after LO push -> HI held, pushed first cycle ready=1; ustrm_ready=0 once 2 flits buffered.
REQ-035 Gen1 rx word phase=1 in RX_LO -> no dstrm_valid, rx_align_err=1, rx_err_cnt=1 (macro on) / 0 (macro off).
REQ-036 300 injected phase errors with macro on -> rx_err_cnt=255.
REQ-037 reset asserted between LO and HI word -> after release all outputs 0, next complete flit reassembled correctly.

Source files
------------

// File: rtl/lpif_txrx_slave_gbox_if.sv
// LPIF slave gearbox bus: upstream flit in, link words out/in, downstream flit out, rx error status.
// slave = gearbox side, master = the surrounding adapter/bench side.
interface lpif_txrx_slave_gbox_if #(
    parameter int DATA_W = 128,
    parameter int CRC_W  = 16
);
    localparam int FW = 4 + 2 + DATA_W + 1 + CRC_W + 1 + 1;

    logic [3:0]        ustrm_state;
    logic [1:0]        ustrm_protid;
    logic [DATA_W-1:0] ustrm_data;
    logic              ustrm_dvalid;
    logic [CRC_W-1:0]  ustrm_crc;
    logic              ustrm_crc_valid;
    logic              ustrm_valid;
    logic              ustrm_ready;

    logic [FW-1:0]     txfifo_upstream_data;
    logic              txfifo_upstream_phase;
    logic              txfifo_upstream_push;
    logic              txfifo_upstream_ready;

    logic [FW-1:0]     rxfifo_downstream_data;
    logic              rxfifo_downstream_phase;
    logic              rxfifo_downstream_valid;

    logic [3:0]        dstrm_state;
    logic [1:0]        dstrm_protid;
    logic [DATA_W-1:0] dstrm_data;
    logic              dstrm_dvalid;
    logic [CRC_W-1:0]  dstrm_crc;
    logic              dstrm_crc_valid;
    logic              dstrm_valid;

    logic              rx_align_err;
    logic [7:0]        rx_err_cnt;

    modport slave (
        input  ustrm_state, ustrm_protid, ustrm_data, ustrm_dvalid, ustrm_crc, ustrm_crc_valid, ustrm_valid,
        output ustrm_ready,
        output txfifo_upstream_data, txfifo_upstream_phase, txfifo_upstream_push,
        input  txfifo_upstream_ready,
        input  rxfifo_downstream_data, rxfifo_downstream_phase, rxfifo_downstream_valid,
        output dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid, dstrm_crc, dstrm_crc_valid, dstrm_valid,
        output rx_align_err, rx_err_cnt
    );

    modport master (
        output ustrm_state, ustrm_protid, ustrm_data, ustrm_dvalid, ustrm_crc, ustrm_crc_valid, ustrm_valid,
        input  ustrm_ready,
        input  txfifo_upstream_data, txfifo_upstream_phase, txfifo_upstream_push,
        output txfifo_upstream_ready,
        output rxfifo_downstream_data, rxfifo_downstream_phase, rxfifo_downstream_valid,
        input  dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid, dstrm_crc, dstrm_crc_valid, dstrm_valid,
        input  rx_align_err, rx_err_cnt
    );
endinterface

// File: rtl/lpif_txrx_slave_gbox.sv
// lpif_fifo: small generic FIFO, head entry visible combinationally.
// Latency: written entry visible at head the cycle after push.
// Backpressure: caller must not push when full nor pop when empty.
module lpif_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          lclk,
    input  logic          reset,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_vld,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] count,
    output logic          full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_vld) wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop_vld)  rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        cnt_d = cnt_q + CW'(push_vld) - CW'(pop_vld);
    end

    always_ff @(posedge lclk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (push_vld) mem_q[wr_ptr_q] <= push_dat;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = cnt_q;
    assign full     = (cnt_q == CW'(DEPTH));
endmodule

// lpif_txrx_slave_gbox: LPIF flit gearbox, full/half-rate link words out, reassembly in; LPIF_TXRX_SLAVE_GBOX_ERR_CNT_EN enables rx_err_cnt.
// Latency: first link word pushed 1 cycle after flit accept; reassembled flit out 1 cycle after its last link word.
// Backpressure: ustrm_ready drops with 2 flits buffered; link ready low freezes current word, phase and FSM.
module lpif_txrx_slave_gbox #(
    parameter int DATA_W = 128,
    parameter int CRC_W  = 16
) (
    input  logic                  lclk,
    input  logic                  reset,
    input  logic                  m_gen2_mode,
    lpif_txrx_slave_gbox_if.slave bus
);
    localparam int FW       = 4 + 2 + DATA_W + 1 + CRC_W + 1 + 1;
    localparam int HW       = (FW + 1) / 2;
    localparam int LW       = FW - HW;
    localparam int TX_DEPTH = 2;
    localparam int CW       = $clog2(TX_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} tx_state_e;
    typedef enum logic       {RX_LO, RX_HI}           rx_state_e;

    tx_state_e     tx_state_q, tx_state_d;
    rx_state_e     rx_state_q, rx_state_d;
    logic          gen2_q, gen2_d;
    logic          rst_done_q, rst_done_d;
    logic [HW-1:0] lo_q, lo_d;
    logic [FW-1:0] out_q, out_d;
    logic          align_q, align_d;
    logic          err_ev;

    logic [FW-1:0] up_pk, head;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_full, accept, pop, start;
    logic [FW-1:0] tx_dat;
    logic          tx_phase, tx_push;

    assign up_pk = {bus.ustrm_valid, bus.ustrm_crc_valid, bus.ustrm_crc, bus.ustrm_dvalid,
                    bus.ustrm_data, bus.ustrm_protid, bus.ustrm_state};

    // Ready stays low until the first clock edge after reset releases.
    assign rst_done_d      = 1'b1;
    assign bus.ustrm_ready = rst_done_q & ~fifo_full;
    assign accept          = bus.ustrm_valid & bus.ustrm_ready;

    lpif_fifo #(.W(FW), .DEPTH(TX_DEPTH), .CW(CW)) u_tx_fifo (
        .lclk     (lclk),
        .reset    (reset),
        .push_vld (accept),
        .push_dat (up_pk),
        .pop_vld  (pop),
        .head_dat (head),
        .count    (fifo_cnt),
        .full     (fifo_full)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        gen2_d     = gen2_q;
        pop        = 1'b0;
        start      = 1'b0;
        tx_dat     = '0;
        tx_phase   = 1'b0;
        tx_push    = 1'b0;
        case (tx_state_q)
            IDLE: start = 1'b1;
            SEND_LO: begin
                tx_push = bus.txfifo_upstream_ready;
                tx_dat  = gen2_q ? head : {{LW{1'b0}}, head[HW-1:0]};
                if (bus.txfifo_upstream_ready) begin
                    if (gen2_q) begin
                        pop   = 1'b1;
                        start = 1'b1;
                    end else begin
                        tx_state_d = SEND_HI;
                    end
                end
            end
            SEND_HI: begin
                tx_push  = bus.txfifo_upstream_ready;
                tx_phase = 1'b1;
                tx_dat   = {{HW{1'b0}}, head[FW-1:HW]};
                if (bus.txfifo_upstream_ready) begin
                    pop   = 1'b1;
                    start = 1'b1;
                end
            end
            default: tx_state_d = IDLE;
        endcase
        // Chain straight into the next flit so the link sees no bubble; mode is captured per flit here.
        if (start) begin
            if (accept || (fifo_cnt > CW'(pop))) begin
                tx_state_d = SEND_LO;
                gen2_d     = m_gen2_mode;
            end else begin
                tx_state_d = IDLE;
            end
        end
    end

    assign bus.txfifo_upstream_data  = tx_dat;
    assign bus.txfifo_upstream_phase = tx_phase;
    assign bus.txfifo_upstream_push  = tx_push;

    always_comb begin
        rx_state_d = rx_state_q;
        lo_d       = lo_q;
        out_d      = '0;
        err_ev     = 1'b0;
        if (bus.rxfifo_downstream_valid) begin
            if (m_gen2_mode) begin
                rx_state_d = RX_LO;
                if (!bus.rxfifo_downstream_phase) out_d  = bus.rxfifo_downstream_data;
                else                              err_ev = 1'b1;
            end else if (rx_state_q == RX_LO) begin
                if (!bus.rxfifo_downstream_phase) begin
                    lo_d       = bus.rxfifo_downstream_data[HW-1:0];
                    rx_state_d = RX_HI;
                end else begin
                    err_ev = 1'b1;
                end
            end else begin
                if (bus.rxfifo_downstream_phase) begin
                    out_d      = {bus.rxfifo_downstream_data[LW-1:0], lo_q};
                    rx_state_d = RX_LO;
                end else begin
                    // A fresh low half supersedes the orphaned one; keep waiting for its high half.
                    lo_d   = bus.rxfifo_downstream_data[HW-1:0];
                    err_ev = 1'b1;
                end
            end
        end
        align_d = align_q | err_ev;
    end

    always_ff @(posedge lclk or posedge reset) begin
        if (reset) begin
            tx_state_q <= IDLE;
            rx_state_q <= RX_LO;
            gen2_q     <= 1'b0;
            rst_done_q <= 1'b0;
            lo_q       <= '0;
            out_q      <= '0;
            align_q    <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            gen2_q     <= gen2_d;
            rst_done_q <= rst_done_d;
            lo_q       <= lo_d;
            out_q      <= out_d;
            align_q    <= align_d;
        end
    end

    assign bus.dstrm_state     = out_q[3:0];
    assign bus.dstrm_protid    = out_q[5:4];
    assign bus.dstrm_data      = out_q[6 +: DATA_W];
    assign bus.dstrm_dvalid    = out_q[6 + DATA_W];
    assign bus.dstrm_crc       = out_q[7 + DATA_W +: CRC_W];
    assign bus.dstrm_crc_valid = out_q[FW-2];
    assign bus.dstrm_valid     = out_q[FW-1];
    assign bus.rx_align_err    = align_q;

`ifdef LPIF_TXRX_SLAVE_GBOX_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_ev && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge lclk or posedge reset) begin
        if (reset) err_cnt_q <= 8'd0;
        else       err_cnt_q <= err_cnt_d;
    end

    assign bus.rx_err_cnt = err_cnt_q;
`else
    assign bus.rx_err_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_lpif_txrx_slave_gbox.sv
// Directed bench for lpif_txrx_slave_gbox: link-word and flit scoreboards, tx->rx loopback, rx error injection.
module tb_lpif_txrx_slave_gbox;
    localparam int DATA_W = 128;
    localparam int CRC_W  = 16;
    localparam int FW     = 4 + 2 + DATA_W + 1 + CRC_W + 1 + 1;
    localparam int HW     = (FW + 1) / 2;
    localparam int LW     = FW - HW;
`ifdef LPIF_TXRX_SLAVE_GBOX_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic lclk = 1'b0;
    logic reset;
    logic m_gen2_mode;
    logic lb;
    logic [FW-1:0] rx_dat;
    logic rx_ph, rx_vld;

    always #5 lclk = ~lclk;

    lpif_txrx_slave_gbox_if #(.DATA_W(DATA_W), .CRC_W(CRC_W)) bus ();

    lpif_txrx_slave_gbox #(.DATA_W(DATA_W), .CRC_W(CRC_W)) dut (
        .lclk        (lclk),
        .reset       (reset),
        .m_gen2_mode (m_gen2_mode),
        .bus         (bus)
    );

    always_comb begin
        bus.rxfifo_downstream_data  = lb ? bus.txfifo_upstream_data  : rx_dat;
        bus.rxfifo_downstream_phase = lb ? bus.txfifo_upstream_phase : rx_ph;
        bus.rxfifo_downstream_valid = lb ? bus.txfifo_upstream_push  : rx_vld;
    end

    int n_chk = 0, n_fail = 0;
    int cyc_n = 0, push_n = 0, first_push = 0, last_push = 0;
    logic [5:0] phs;
    logic acc;
    logic [FW-1:0] acc_flit;
    logic [FW-1:0] tx_q[$];
    logic          ph_q[$];
    logic [FW-1:0] rx_q[$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_cnt(input int n);
        return CNT_EN ? ((n > 255) ? 255 : n) : 0;
    endfunction

    function automatic logic [FW-1:0] pk_up();
        return {bus.ustrm_valid, bus.ustrm_crc_valid, bus.ustrm_crc, bus.ustrm_dvalid,
                bus.ustrm_data, bus.ustrm_protid, bus.ustrm_state};
    endfunction

    function automatic logic [FW-1:0] pk_dn();
        return {bus.dstrm_valid, bus.dstrm_crc_valid, bus.dstrm_crc, bus.dstrm_dvalid,
                bus.dstrm_data, bus.dstrm_protid, bus.dstrm_state};
    endfunction

    function automatic logic [FW-1:0] rnd_word();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r[FW-1:0];
    endfunction

    task automatic rand_flit();
        bus.ustrm_state     = 4'($urandom);
        bus.ustrm_protid    = 2'($urandom);
        bus.ustrm_data      = {$urandom, $urandom, $urandom, $urandom};
        bus.ustrm_dvalid    = 1'($urandom);
        bus.ustrm_crc       = 16'($urandom);
        bus.ustrm_crc_valid = 1'($urandom);
        bus.ustrm_valid     = 1'b1;
    endtask

    // One clock: observe at the falling edge, return just after the next rising edge.
    task automatic cyc();
        logic [FW-1:0] f, w;
        logic p;
        @(negedge lclk);
        cyc_n++;
        acc = 1'b0;
        if (bus.ustrm_valid && bus.ustrm_ready) begin
            acc      = 1'b1;
            f        = pk_up();
            acc_flit = f;
            if (m_gen2_mode) begin
                tx_q.push_back(f);
                ph_q.push_back(1'b0);
            end else begin
                tx_q.push_back({{LW{1'b0}}, f[HW-1:0]});
                ph_q.push_back(1'b0);
                tx_q.push_back({{HW{1'b0}}, f[FW-1:HW]});
                ph_q.push_back(1'b1);
            end
            if (lb) rx_q.push_back(f);
        end
        if (bus.txfifo_upstream_push) begin
            if (push_n == 0) first_push = cyc_n;
            last_push = cyc_n;
            push_n++;
            phs = {phs[4:0], bus.txfifo_upstream_phase};
            if (tx_q.size() == 0) begin
                chk("tx_unexpected_push", bus.txfifo_upstream_push, 0);
            end else begin
                w = tx_q.pop_front();
                p = ph_q.pop_front();
                chk("tx_word", bus.txfifo_upstream_data, w);
                chk("tx_phase", bus.txfifo_upstream_phase, p);
            end
        end
        if (bus.dstrm_valid) begin
            if (rx_q.size() == 0) chk("rx_unexpected_flit", bus.dstrm_valid, 0);
            else                  chk("rx_flit", pk_dn(), rx_q.pop_front());
        end else begin
            chk("dstrm_idle_zero", pk_dn(), 0);
        end
        @(posedge lclk);
        #1;
    endtask

    task automatic wait_acc(input string tag);
        int k;
        k = 0;
        do begin
            cyc();
            k++;
        end while (!acc && k < 20);
        chk(tag, acc, 1);
    endtask

    task automatic rx_word(input logic [FW-1:0] w, input logic p);
        rx_dat = w;
        rx_ph  = p;
        rx_vld = 1'b1;
        cyc();
        rx_vld = 1'b0;
    endtask

    logic [DATA_W-1:0] a5;
    logic [FW-1:0] x_pk, w0, w1, w2;

    initial begin
        a5 = {16{8'hA5}};
        phs = '0;
        lb = 1'b1;
        rx_dat = '0; rx_ph = 1'b0; rx_vld = 1'b0;
        m_gen2_mode = 1'b1;
        bus.ustrm_state = '0; bus.ustrm_protid = '0; bus.ustrm_data = '0; bus.ustrm_dvalid = 1'b0;
        bus.ustrm_crc = '0; bus.ustrm_crc_valid = 1'b0; bus.ustrm_valid = 1'b0;
        bus.txfifo_upstream_ready = 1'b1;
        reset = 1'b0;
        #1 reset = 1'b1;

        // Reset state
        repeat (2) cyc();
        chk("rst_ustrm_ready", bus.ustrm_ready, 0);
        chk("rst_push", bus.txfifo_upstream_push, 0);
        chk("rst_phase", bus.txfifo_upstream_phase, 0);
        chk("rst_txdata", bus.txfifo_upstream_data, 0);
        chk("rst_dstrm", pk_dn(), 0);
        chk("rst_align", bus.rx_align_err, 0);
        chk("rst_errcnt", bus.rx_err_cnt, 0);
        reset = 1'b0;
        cyc();
        chk("ready_after_rst", bus.ustrm_ready, 1);

        // Gen2 single flit with loopback
        bus.ustrm_state = 4'h3; bus.ustrm_protid = 2'h1; bus.ustrm_data = a5; bus.ustrm_dvalid = 1'b1;
        bus.ustrm_crc = 16'hBEEF; bus.ustrm_crc_valid = 1'b1; bus.ustrm_valid = 1'b1;
        cyc();
        chk("g2_accept_c0", acc, 1);
        bus.ustrm_valid = 1'b0;
        chk("g2_push_c1", bus.txfifo_upstream_push, 1);
        chk("g2_phase_c1", bus.txfifo_upstream_phase, 0);
        chk("g2_data_c1", bus.txfifo_upstream_data[133:6], a5);
        cyc();
        chk("g2_dvalid_c2", bus.dstrm_valid, 1);
        chk("g2_ddata_c2", bus.dstrm_data, a5);
        chk("g2_dcrc_c2", bus.dstrm_crc, 16'hBEEF);
        repeat (3) cyc();
        chk("g2_drain", tx_q.size() + rx_q.size(), 0);

        // Gen1, three back-to-back flits
        m_gen2_mode = 1'b0;
        push_n = 0; phs = '0;
        for (int i = 0; i < 3; i++) begin
            rand_flit();
            wait_acc("g1_b2b_accept");
        end
        bus.ustrm_valid = 1'b0;
        repeat (10) cyc();
        chk("g1_push_count", push_n, 6);
        chk("g1_push_span", last_push - first_push, 5);
        chk("g1_phases", phs, 6'b010101);
        chk("g1_drain", tx_q.size() + rx_q.size(), 0);

        // Gen1 link stall between LO and HI words
        rand_flit();
        wait_acc("st_accept_x");
        x_pk = acc_flit;
        rand_flit();
        cyc();
        chk("st_accept_y", acc, 1);
        bus.txfifo_upstream_ready = 1'b0;
        rand_flit();
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("st_hold_push", bus.txfifo_upstream_push, 0);
            chk("st_hold_phase", bus.txfifo_upstream_phase, 1);
            chk("st_hold_data", bus.txfifo_upstream_data, {{HW{1'b0}}, x_pk[FW-1:HW]});
            chk("st_full_ready", bus.ustrm_ready, 0);
            cyc();
        end
        bus.txfifo_upstream_ready = 1'b1;
        #1;
        chk("st_release_push", bus.txfifo_upstream_push, 1);
        chk("st_release_data", bus.txfifo_upstream_data, {{HW{1'b0}}, x_pk[FW-1:HW]});
        wait_acc("st_accept_z");
        bus.ustrm_valid = 1'b0;
        repeat (12) cyc();
        chk("st_drain", tx_q.size() + rx_q.size(), 0);

        // Rx error handling with direct injection
        lb = 1'b0;
        chk("rx_align_clean", bus.rx_align_err, 0);
        rx_word(rnd_word(), 1'b1);
        chk("r_lo_ph1_align", bus.rx_align_err, 1);
        chk("r_lo_ph1_cnt", bus.rx_err_cnt, exp_cnt(1));
        chk("r_lo_ph1_novalid", bus.dstrm_valid, 0);
        w0 = rnd_word();
        rx_word(w0, 1'b0);
        w1 = rnd_word();
        rx_word(w1, 1'b0);
        chk("r_hi_ph0_cnt", bus.rx_err_cnt, exp_cnt(2));
        w2 = rnd_word();
        w2[LW-1] = 1'b1;
        rx_q.push_back({w2[LW-1:0], w1[HW-1:0]});
        rx_word(w2, 1'b1);
        cyc();
        chk("r_reassembly_drain", rx_q.size(), 0);

        m_gen2_mode = 1'b1;
        rx_word(rnd_word(), 1'b1);
        chk("r_g2_ph1_cnt", bus.rx_err_cnt, exp_cnt(3));
        chk("r_g2_ph1_novalid", bus.dstrm_valid, 0);
        w0 = rnd_word();
        w0[FW-1] = 1'b1;
        rx_q.push_back(w0);
        rx_word(w0, 1'b0);
        cyc();
        chk("r_g2_drain", rx_q.size(), 0);

        // Error counter saturation
        m_gen2_mode = 1'b0;
        rx_dat = rnd_word(); rx_ph = 1'b1; rx_vld = 1'b1;
        repeat (300) cyc();
        rx_vld = 1'b0;
        cyc();
        chk("r_sat_cnt", bus.rx_err_cnt, exp_cnt(303));
        chk("r_sat_align", bus.rx_align_err, 1);

        // Reset between LO and HI words
        lb = 1'b1;
        rand_flit();
        wait_acc("mr_accept");
        bus.ustrm_valid = 1'b0;
        cyc();
        reset = 1'b1;
        #1;
        chk("mr_push", bus.txfifo_upstream_push, 0);
        chk("mr_txdata", bus.txfifo_upstream_data, 0);
        chk("mr_phase", bus.txfifo_upstream_phase, 0);
        chk("mr_ready", bus.ustrm_ready, 0);
        chk("mr_align", bus.rx_align_err, 0);
        chk("mr_cnt", bus.rx_err_cnt, 0);
        tx_q.delete(); ph_q.delete(); rx_q.delete();
        cyc();
        reset = 1'b0;
        cyc();
        chk("mr_post_ready", bus.ustrm_ready, 1);
        chk("mr_post_dstrm", pk_dn(), 0);
        chk("mr_post_push", bus.txfifo_upstream_push, 0);
        rand_flit();
        wait_acc("mr_accept2");
        bus.ustrm_valid = 1'b0;
        repeat (8) cyc();
        chk("mr_drain", tx_q.size() + rx_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
